// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: opcodes, control-bundle bit map and the
// ID/EX register payload.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 11;

    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] LOAD = 7'b0000011;
    localparam logic [6:0] SAVE = 7'b0100011;
    localparam logic [6:0] AR   = 7'b0110011;
    localparam logic [6:0] AI   = 7'b0010011;
    localparam logic [6:0] J    = 7'b1101111;
    localparam logic [6:0] Jr   = 7'b1100111;
    localparam logic [6:0] Lui  = 7'b0110111;
    localparam logic [6:0] Au   = 7'b0010111;
    localparam logic [6:0] Csr  = 7'b1110011;

    // Control bundle bit indices, bit 0 is the LSB of id_ctrl_i.
    localparam int C_IS_BRANCH = 0;
    localparam int C_MEM_READ  = 1;
    localparam int C_MEM2REG   = 2;
    localparam int C_ALU_OP    = 3;
    localparam int C_MEM_WEN   = 4;
    localparam int C_ALU_SRC   = 5;
    localparam int C_REG_WEN   = 6;
    localparam int C_IS_JAL    = 7;
    localparam int C_IS_JALR   = 8;
    localparam int C_IS_LUI    = 9;
    localparam int C_IS_AUIPC  = 10;

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic              funct7b5;
    } ex_bundle_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side registered outputs of the ID/EX pipeline register.
// master = decode/testbench side, slave = id_ex_stage.
interface id_ex_stage_if;
    import cpu_pkg::*;

    logic              id_valid_i;
    logic [CTRL_W-1:0] id_ctrl_i;
    logic [XLEN-1:0]   id_pc_i;
    logic [XLEN-1:0]   id_imm_i;
    logic [XLEN-1:0]   id_rs1_data_i;
    logic [XLEN-1:0]   id_rs2_data_i;
    logic [4:0]        id_rs1_i;
    logic [4:0]        id_rs2_i;
    logic [4:0]        id_rd_i;
    logic [2:0]        id_funct3_i;
    logic              id_funct7b5_i;

    logic              ex_valid_o;
    logic [CTRL_W-1:0] ex_ctrl_o;
    logic [XLEN-1:0]   ex_pc_o;
    logic [XLEN-1:0]   ex_imm_o;
    logic [XLEN-1:0]   ex_rs1_data_o;
    logic [XLEN-1:0]   ex_rs2_data_o;
    logic [4:0]        ex_rs1_o;
    logic [4:0]        ex_rs2_o;
    logic [4:0]        ex_rd_o;
    logic [2:0]        ex_funct3_o;
    logic              ex_funct7b5_o;

    modport master (
        output id_valid_i, id_ctrl_i, id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i,
               id_rs1_i, id_rs2_i, id_rd_i, id_funct3_i, id_funct7b5_i,
        input  ex_valid_o, ex_ctrl_o, ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o,
               ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_funct7b5_o
    );

    modport slave (
        input  id_valid_i, id_ctrl_i, id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i,
               id_rs1_i, id_rs2_i, id_rd_i, id_funct3_i, id_funct7b5_i,
        output ex_valid_o, ex_ctrl_o, ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o,
               ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_funct7b5_o
    );

endinterface

// File: rtl/id_ex_hazard.sv
// Combinational load-use detector: a load in EX whose rd is read by the
// valid instruction in ID. x0 never creates a dependency.
module id_ex_hazard (
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_is_lui,
    input  logic       i_is_jal,
    input  logic       i_is_auipc,
    input  logic       i_alu_src,
    input  logic       i_mem_wen,
    input  logic       i_is_branch,
    output logic       o_hazard
);

    logic w_use_rs1;
    logic w_use_rs2;
    logic w_ex_load;

    assign w_use_rs1 = ~(i_is_lui | i_is_jal | i_is_auipc);
    assign w_use_rs2 = i_alu_src | i_mem_wen | i_is_branch;
    assign w_ex_load = i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0);

    assign o_hazard = w_ex_load & i_id_valid &
                      ((w_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                       (w_use_rs2 & (i_id_rs2 == i_ex_rd)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional perf counters are enabled by defining ID_EX_PERF_EN.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus,
    input  logic         flush_i,
    input  logic         ex_hold_i,
    output logic         stall_o
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]  bubble_cnt_o,
    output logic [31:0]  flush_cnt_o
`endif
);

    ex_bundle_t r_ex;
    ex_bundle_t w_id;
    logic       w_hazard;

    id_ex_hazard u_hazard (
        .i_ex_valid    (r_ex.valid),
        .i_ex_mem_read (r_ex.ctrl[C_MEM_READ]),
        .i_ex_rd       (r_ex.rd),
        .i_id_valid    (bus.id_valid_i),
        .i_id_rs1      (bus.id_rs1_i),
        .i_id_rs2      (bus.id_rs2_i),
        .i_is_lui      (bus.id_ctrl_i[C_IS_LUI]),
        .i_is_jal      (bus.id_ctrl_i[C_IS_JAL]),
        .i_is_auipc    (bus.id_ctrl_i[C_IS_AUIPC]),
        .i_alu_src     (bus.id_ctrl_i[C_ALU_SRC]),
        .i_mem_wen     (bus.id_ctrl_i[C_MEM_WEN]),
        .i_is_branch   (bus.id_ctrl_i[C_IS_BRANCH]),
        .o_hazard      (w_hazard)
    );

    always_comb begin
        w_id          = '0;
        w_id.valid    = bus.id_valid_i;
        w_id.ctrl     = bus.id_valid_i ? bus.id_ctrl_i : '0;
        w_id.pc       = bus.id_pc_i;
        w_id.imm      = bus.id_imm_i;
        w_id.rs1_data = bus.id_rs1_data_i;
        w_id.rs2_data = bus.id_rs2_data_i;
        w_id.rs1      = bus.id_rs1_i;
        w_id.rs2      = bus.id_rs2_i;
        w_id.rd       = bus.id_rd_i;
        w_id.funct3   = bus.id_funct3_i;
        w_id.funct7b5 = bus.id_funct7b5_i;
    end

    // Flush kills the ID instruction outright, so nothing upstream needs to wait.
    assign stall_o = rst_n & ~flush_i & (ex_hold_i | w_hazard);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else if (flush_i) begin
            r_ex <= '0;
        end else if (!ex_hold_i) begin
            r_ex <= w_hazard ? '0 : w_id;
        end
    end

    assign bus.ex_valid_o    = r_ex.valid;
    assign bus.ex_ctrl_o     = r_ex.ctrl;
    assign bus.ex_pc_o       = r_ex.pc;
    assign bus.ex_imm_o      = r_ex.imm;
    assign bus.ex_rs1_data_o = r_ex.rs1_data;
    assign bus.ex_rs2_data_o = r_ex.rs2_data;
    assign bus.ex_rs1_o      = r_ex.rs1;
    assign bus.ex_rs2_o      = r_ex.rs2;
    assign bus.ex_rd_o       = r_ex.rd;
    assign bus.ex_funct3_o   = r_ex.funct3;
    assign bus.ex_funct7b5_o = r_ex.funct7b5;

`ifdef ID_EX_PERF_EN
    logic        w_bubble;
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    // Only count a bubble when it is actually written into the register.
    assign w_bubble = w_hazard & ~flush_i & ~ex_hold_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (flush_i && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
    assign flush_cnt_o  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage; perf counter checks compile in with ID_EX_PERF_EN.
module tb_id_ex_stage;
    import cpu_pkg::*;

    // Hand-encoded control bundles (bit0 = is_branch ... bit10 = is_auipc).
    localparam logic [CTRL_W-1:0] CT_LW   = 11'h046; // reg_wen mem2reg mem_read
    localparam logic [CTRL_W-1:0] CT_ADD  = 11'h068; // reg_wen ALU_src ALU_op
    localparam logic [CTRL_W-1:0] CT_ADDI = 11'h048; // reg_wen ALU_op
    localparam logic [CTRL_W-1:0] CT_SW   = 11'h010; // mem_wen
    localparam logic [CTRL_W-1:0] CT_LUI  = 11'h240; // is_lui reg_wen

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_i = 1'b0;
    logic ex_hold_i = 1'b0;
    logic stall_o;
    int   tests_run = 0;
    int   tests_failed = 0;
`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt_o;
    logic [31:0] flush_cnt_o;
    int          exp_bubble = 0;
    int          exp_flush = 0;
`endif

    id_ex_stage_if ifc ();

    id_ex_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc.slave),
        .flush_i   (flush_i),
        .ex_hold_i (ex_hold_i),
        .stall_o   (stall_o)
`ifdef ID_EX_PERF_EN
        ,
        .bubble_cnt_o (bubble_cnt_o),
        .flush_cnt_o  (flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [CTRL_W-1:0] c, input logic [31:0] pc,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        ifc.id_valid_i    = v;
        ifc.id_ctrl_i     = c;
        ifc.id_pc_i       = pc;
        ifc.id_imm_i      = pc ^ 32'h5a5a_0000;
        ifc.id_rs1_data_i = {27'd0, rs1} + 32'h1000;
        ifc.id_rs2_data_i = {27'd0, rs2} + 32'h2000;
        ifc.id_rs1_i      = rs1;
        ifc.id_rs2_i      = rs2;
        ifc.id_rd_i       = rd;
        ifc.id_funct3_i   = pc[4:2];
        ifc.id_funct7b5_i = pc[2];
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_hold_i = 1'b1;
        set_id(1'b1, CT_LW, 32'h40, 5'd1, 5'd0, 5'd5);
        step();
        set_id(1'b1, CT_ADD, 32'h44, 5'd5, 5'd1, 5'd6);
        step();
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got=%0h exp=0", stall_o); end
        tests_run++; if (ifc.ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%0h exp=0", ifc.ex_valid_o); end
        tests_run++; if (ifc.ex_ctrl_o !== '0) begin tests_failed++; $display("FAIL reset_ctrl got=%0h exp=0", ifc.ex_ctrl_o); end
        tests_run++; if (ifc.ex_pc_o !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got=%0h exp=0", ifc.ex_pc_o); end
        tests_run++; if (ifc.ex_rd_o !== 5'd0) begin tests_failed++; $display("FAIL reset_rd got=%0h exp=0", ifc.ex_rd_o); end
`ifdef ID_EX_PERF_EN
        tests_run++; if (bubble_cnt_o !== 32'd0) begin tests_failed++; $display("FAIL reset_bubble_cnt got=%0d exp=0", bubble_cnt_o); end
        tests_run++; if (flush_cnt_o !== 32'd0) begin tests_failed++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt_o); end
`endif
        ex_hold_i = 1'b0;
        rst_n = 1'b1;
        set_id(1'b0, '0, 32'h0, 5'd0, 5'd0, 5'd0);
        step();
    endtask

    task automatic test_load_use();
        set_id(1'b1, CT_LW, 32'h100, 5'd1, 5'd0, 5'd5);
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL lu_pre_stall got=%0h exp=0", stall_o); end
        step();
        tests_run++; if (ifc.ex_ctrl_o !== CT_LW) begin tests_failed++; $display("FAIL lu_lw_ctrl got=%0h exp=%0h", ifc.ex_ctrl_o, CT_LW); end
        tests_run++; if (ifc.ex_rs1_data_o !== 32'h1001) begin tests_failed++; $display("FAIL lu_lw_rs1data got=%0h exp=1001", ifc.ex_rs1_data_o); end
        set_id(1'b1, CT_ADD, 32'h104, 5'd5, 5'd1, 5'd6);
        tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL lu_stall got=%0h exp=1", stall_o); end
        step();
`ifdef ID_EX_PERF_EN
        exp_bubble++;
`endif
        tests_run++; if (ifc.ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL lu_bubble_valid got=%0h exp=0", ifc.ex_valid_o); end
        tests_run++; if (ifc.ex_ctrl_o !== '0) begin tests_failed++; $display("FAIL lu_bubble_ctrl got=%0h exp=0", ifc.ex_ctrl_o); end
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL lu_stall_release got=%0h exp=0", stall_o); end
        step();
        tests_run++; if (ifc.ex_valid_o !== 1'b1) begin tests_failed++; $display("FAIL lu_add_valid got=%0h exp=1", ifc.ex_valid_o); end
        tests_run++; if (ifc.ex_rs1_o !== 5'd5) begin tests_failed++; $display("FAIL lu_add_rs1 got=%0d exp=5", ifc.ex_rs1_o); end
        tests_run++; if (ifc.ex_pc_o !== 32'h104) begin tests_failed++; $display("FAIL lu_add_pc got=%0h exp=104", ifc.ex_pc_o); end
        tests_run++; if (ifc.ex_imm_o !== 32'h5a5a_0104) begin tests_failed++; $display("FAIL lu_add_imm got=%0h exp=5a5a0104", ifc.ex_imm_o); end
        tests_run++; if ({ifc.ex_funct3_o, ifc.ex_funct7b5_o} !== 4'b0011) begin tests_failed++; $display("FAIL lu_add_funct got=%0h exp=3", {ifc.ex_funct3_o, ifc.ex_funct7b5_o}); end
        // rs2 dependency through a register-register ALU op
        set_id(1'b1, CT_LW, 32'h108, 5'd2, 5'd0, 5'd5);
        step();
        set_id(1'b1, CT_ADD, 32'h10c, 5'd1, 5'd5, 5'd6);
        tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL lu_rs2_stall got=%0h exp=1", stall_o); end
        step();
`ifdef ID_EX_PERF_EN
        exp_bubble++;
`endif
        step();
        tests_run++; if (ifc.ex_pc_o !== 32'h10c) begin tests_failed++; $display("FAIL lu_rs2_pc got=%0h exp=10c", ifc.ex_pc_o); end
    endtask

    task automatic test_no_hazard();
        set_id(1'b1, CT_LW, 32'h110, 5'd2, 5'd0, 5'd0);
        step();
        set_id(1'b1, CT_ADD, 32'h114, 5'd0, 5'd1, 5'd6);
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL x0_stall got=%0h exp=0", stall_o); end
        step();
        tests_run++; if (ifc.ex_pc_o !== 32'h114) begin tests_failed++; $display("FAIL x0_pc got=%0h exp=114", ifc.ex_pc_o); end
        set_id(1'b1, CT_LW, 32'h120, 5'd2, 5'd0, 5'd5);
        step();
        set_id(1'b1, CT_LUI, 32'h124, 5'd5, 5'd5, 5'd5);
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL lui_stall got=%0h exp=0", stall_o); end
        step();
        tests_run++; if (ifc.ex_ctrl_o !== CT_LUI) begin tests_failed++; $display("FAIL lui_ctrl got=%0h exp=%0h", ifc.ex_ctrl_o, CT_LUI); end
        set_id(1'b1, CT_LW, 32'h130, 5'd2, 5'd0, 5'd5);
        step();
        set_id(1'b0, CT_ADD, 32'h134, 5'd5, 5'd1, 5'd6);
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL inv_stall got=%0h exp=0", stall_o); end
        step();
        tests_run++; if (ifc.ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL inv_valid got=%0h exp=0", ifc.ex_valid_o); end
        tests_run++; if (ifc.ex_ctrl_o !== '0) begin tests_failed++; $display("FAIL inv_ctrl got=%0h exp=0", ifc.ex_ctrl_o); end
        tests_run++; if (ifc.ex_pc_o !== 32'h134) begin tests_failed++; $display("FAIL inv_pc got=%0h exp=134", ifc.ex_pc_o); end
    endtask

    task automatic test_store();
        set_id(1'b1, CT_LW, 32'h140, 5'd2, 5'd0, 5'd5);
        step();
        set_id(1'b1, CT_SW, 32'h144, 5'd2, 5'd5, 5'd0);
        tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL sw_stall got=%0h exp=1", stall_o); end
        step();
`ifdef ID_EX_PERF_EN
        exp_bubble++;
`endif
        tests_run++; if (ifc.ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL sw_bubble got=%0h exp=0", ifc.ex_valid_o); end
        step();
        tests_run++; if (ifc.ex_ctrl_o !== CT_SW) begin tests_failed++; $display("FAIL sw_ctrl got=%0h exp=%0h", ifc.ex_ctrl_o, CT_SW); end
        tests_run++; if (ifc.ex_rs2_data_o !== 32'h2005) begin tests_failed++; $display("FAIL sw_rs2data got=%0h exp=2005", ifc.ex_rs2_data_o); end
    endtask

    task automatic test_flush();
        set_id(1'b1, CT_LW, 32'h150, 5'd2, 5'd0, 5'd5);
        step();
        set_id(1'b1, CT_ADD, 32'h154, 5'd5, 5'd1, 5'd6);
        flush_i = 1'b1;
        #1;
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL fl_stall got=%0h exp=0", stall_o); end
        step();
`ifdef ID_EX_PERF_EN
        exp_flush++;
`endif
        flush_i = 1'b0;
        tests_run++; if (ifc.ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL fl_valid got=%0h exp=0", ifc.ex_valid_o); end
        tests_run++; if (ifc.ex_ctrl_o !== '0) begin tests_failed++; $display("FAIL fl_ctrl got=%0h exp=0", ifc.ex_ctrl_o); end
        tests_run++; if (ifc.ex_pc_o !== 32'h0) begin tests_failed++; $display("FAIL fl_pc got=%0h exp=0", ifc.ex_pc_o); end
        step();
        tests_run++; if (ifc.ex_pc_o !== 32'h154) begin tests_failed++; $display("FAIL fl_next_pc got=%0h exp=154", ifc.ex_pc_o); end
        set_id(1'b1, CT_ADDI, 32'h158, 5'd1, 5'd0, 5'd8);
        flush_i = 1'b1;
        ex_hold_i = 1'b1;
        #1;
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL flhold_stall got=%0h exp=0", stall_o); end
        step();
`ifdef ID_EX_PERF_EN
        exp_flush++;
`endif
        flush_i = 1'b0;
        ex_hold_i = 1'b0;
        tests_run++; if (ifc.ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL flhold_valid got=%0h exp=0", ifc.ex_valid_o); end
    endtask

    task automatic test_hold();
        set_id(1'b1, CT_ADDI, 32'h200, 5'd1, 5'd0, 5'd7);
        step();
        set_id(1'b1, CT_ADD, 32'h204, 5'd7, 5'd1, 5'd9);
        ex_hold_i = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL hold_stall[%0d] got=%0h exp=1", i, stall_o); end
            step();
            tests_run++; if (ifc.ex_pc_o !== 32'h200 || ifc.ex_ctrl_o !== CT_ADDI || ifc.ex_rd_o !== 5'd7) begin
                tests_failed++; $display("FAIL hold_fields[%0d] got pc=%0h ctrl=%0h rd=%0d exp pc=200 ctrl=%0h rd=7", i, ifc.ex_pc_o, ifc.ex_ctrl_o, ifc.ex_rd_o, CT_ADDI);
            end
        end
`ifdef ID_EX_PERF_EN
        tests_run++; if (bubble_cnt_o !== 32'(exp_bubble)) begin tests_failed++; $display("FAIL hold_bubble_cnt got=%0d exp=%0d", bubble_cnt_o, exp_bubble); end
`endif
        ex_hold_i = 1'b0;
        #1;
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL hold_release_stall got=%0h exp=0", stall_o); end
        step();
        tests_run++; if (ifc.ex_pc_o !== 32'h204) begin tests_failed++; $display("FAIL hold_release_pc got=%0h exp=204", ifc.ex_pc_o); end
    endtask

    task automatic test_hold_hazard();
        set_id(1'b1, CT_LW, 32'h300, 5'd2, 5'd0, 5'd5);
        step();
        set_id(1'b1, CT_ADD, 32'h304, 5'd5, 5'd1, 5'd6);
        ex_hold_i = 1'b1;
        step();
        step();
        tests_run++; if (ifc.ex_ctrl_o !== CT_LW || ifc.ex_pc_o !== 32'h300) begin tests_failed++; $display("FAIL hh_held got ctrl=%0h pc=%0h exp ctrl=%0h pc=300", ifc.ex_ctrl_o, ifc.ex_pc_o, CT_LW); end
        ex_hold_i = 1'b0;
        #1;
        tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL hh_stall got=%0h exp=1", stall_o); end
        step();
`ifdef ID_EX_PERF_EN
        exp_bubble++;
`endif
        tests_run++; if (ifc.ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL hh_bubble got=%0h exp=0", ifc.ex_valid_o); end
        step();
        tests_run++; if (ifc.ex_pc_o !== 32'h304) begin tests_failed++; $display("FAIL hh_pc got=%0h exp=304", ifc.ex_pc_o); end
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, CT_LW, 32'h400, 5'd1, 5'd0, 5'd5);
        step();
        set_id(1'b1, CT_LW, 32'h404, 5'd5, 5'd0, 5'd6);
        tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_stall1 got=%0h exp=1", stall_o); end
        step();
        step();
        tests_run++; if (ifc.ex_pc_o !== 32'h404) begin tests_failed++; $display("FAIL b2b_lw2_pc got=%0h exp=404", ifc.ex_pc_o); end
        set_id(1'b1, CT_ADD, 32'h408, 5'd6, 5'd5, 5'd7);
        tests_run++; if (stall_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_stall2 got=%0h exp=1", stall_o); end
        step();
        tests_run++; if (ifc.ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_bubble2 got=%0h exp=0", ifc.ex_valid_o); end
        step();
`ifdef ID_EX_PERF_EN
        exp_bubble += 2;
`endif
        tests_run++; if (ifc.ex_pc_o !== 32'h408 || ifc.ex_valid_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_add got pc=%0h v=%0h exp pc=408 v=1", ifc.ex_pc_o, ifc.ex_valid_o); end
    endtask

    task automatic test_perf();
`ifdef ID_EX_PERF_EN
        tests_run++; if (bubble_cnt_o !== 32'(exp_bubble)) begin tests_failed++; $display("FAIL perf_bubble got=%0d exp=%0d", bubble_cnt_o, exp_bubble); end
        tests_run++; if (flush_cnt_o !== 32'(exp_flush)) begin tests_failed++; $display("FAIL perf_flush got=%0d exp=%0d", flush_cnt_o, exp_flush); end
`endif
    endtask

    task automatic test_reset_mid();
        set_id(1'b1, CT_LW, 32'h500, 5'd1, 5'd0, 5'd5);
        step();
        set_id(1'b1, CT_ADD, 32'h504, 5'd5, 5'd1, 5'd6);
        ex_hold_i = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        tests_run++; if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL rm_stall got=%0h exp=0", stall_o); end
        step();
        tests_run++; if (ifc.ex_valid_o !== 1'b0 || ifc.ex_pc_o !== 32'h0) begin tests_failed++; $display("FAIL rm_cleared got v=%0h pc=%0h exp v=0 pc=0", ifc.ex_valid_o, ifc.ex_pc_o); end
`ifdef ID_EX_PERF_EN
        tests_run++; if (bubble_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin tests_failed++; $display("FAIL rm_counters got b=%0d f=%0d exp 0 0", bubble_cnt_o, flush_cnt_o); end
`endif
        rst_n = 1'b1;
        ex_hold_i = 1'b0;
        step();
        tests_run++; if (ifc.ex_pc_o !== 32'h504 || ifc.ex_valid_o !== 1'b1) begin tests_failed++; $display("FAIL rm_resume got pc=%0h v=%0h exp pc=504 v=1", ifc.ex_pc_o, ifc.ex_valid_o); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_store();
        test_flush();
        test_hold();
        test_hold_hazard();
        test_back_to_back();
        test_perf();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage RV32I core, sitting directly downstream of the control decoder and register-file read. Captures the decoded control bundle, operands and register indices each cycle. Detects load-use hazards against the instruction currently in EX, inserting one bubble and stalling IF/ID. Applies branch/jump flush and downstream hold with fixed priority.

## Interface
- XLEN, 32, datapath width for PC, operands, immediate
- CTRL_W, 11, width of decoded control bundle (bit map in package)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid_i  in  1  ID holds a real instruction
- id_ctrl_i  in  CTRL_W  {is_auipc,is_lui,is_jalr,is_jal,reg_wen,ALU_src,mem_wen,ALU_op,mem2reg,mem_read,is_branch}, bit 0 = is_branch
- id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i  in  XLEN each  PC, immediate, register-file read data
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices
- id_funct3_i  in  3;  id_funct7b5_i  in  1  ALU sub-op bits
- flush_i  in  1  EX resolved taken branch/jump; kill ID instruction
- ex_hold_i  in  1  downstream (MEM) not ready; freeze register
- stall_o  out  1  freeze PC and IF/ID (combinational)
- ex_valid_o, ex_ctrl_o, ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_funct3_o, ex_funct7b5_o  out  widths as inputs  registered EX-stage copy

## Operation
- Per-cycle update priority: reset > flush_i > ex_hold_i > load-use > normal load.
- Reset (rst_n=0 at edge): every ex_* output 0, counters 0. stall_o is 0 during reset.
- flush_i=1: load bubble (ex_valid_o=0, ex_ctrl_o=0, other fields don't-care but driven 0); stall_o=0. Flush overrides concurrent hold and load-use.
- ex_hold_i=1 (no flush): all ex_* hold; stall_o=1.
- Load-use: hazard = ex_valid_o & ex_ctrl_o.mem_read & ex_rd_o!=0 & id_valid_i & ((use_rs1 & id_rs1_i==ex_rd_o) | (use_rs2 & id_rs2_i==ex_rd_o)).
  - use_rs1 = !(is_lui | is_jal | is_auipc); use_rs2 = ALU_src | mem_wen | is_branch.
  - On hazard: stall_o=1, register loads bubble. Next cycle ex_valid_o=0, so hazard clears and the held ID instruction loads.
- Normal: all fields load from id_*; ex_valid_o=id_valid_i; ex_ctrl_o forced 0 when id_valid_i=0.
- x0 destination never triggers a hazard.

## Timing
- Latency one cycle ID→EX.
- stall_o combinational from registered EX fields plus id_* and ex_hold_i/flush_i; no path from stall_o back into this block.
- Load-use costs exactly one bubble cycle. Back-to-back loads with dependent consumer: one bubble per dependency.
- Hold plus pending hazard: hold wins; hazard re-evaluated the cycle hold drops.
- Reset mid-operation discards any held or bubbled instruction.

## Configuration
- ID_EX_PERF_EN defined: adds outputs bubble_cnt_o and flush_cnt_o, 32 bits each. They count load-use bubbles and flush cycles, saturate at all-ones, and reset to 0.
- ID_EX_PERF_EN undefined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- The shared package cpu_pkg holds:
  - opcode constants: BR, LOAD, SAVE, AR, AI, J, Jr, Lui, Au, Csr.
  - CTRL_W and the named bit indices of the control bundle.
- One sub-module, id_ex_hazard: purely combinational load-use detector producing the hazard bit. The register and priority logic stay in id_ex_stage.

## Test plan
- Reset then lw x5 followed by add x6,x5,x1 → stall_o=1 for one cycle, EX shows bubble (ex_valid_o=0), add reaches EX next cycle with rs1=5.
- lw x0 followed by add x6,x0,x1 → no stall, add enters EX immediately.
- lw x5 followed by lui x5 → no stall (use_rs1=0).
- lw x5 followed by sw x5,0(x2) → stall one cycle (use_rs2 via mem_wen).
- flush_i=1 asserted in the same cycle as a load-use hazard → stall_o=0, EX bubble, ex_ctrl_o=0.
- ex_hold_i=1 for 3 cycles with addi in EX → ex_* unchanged for 3 cycles, stall_o=1. With ID_EX_PERF_EN, bubble_cnt_o unchanged, and flush_cnt_o increments once per flush cycle.
